ysyx_25060170_ifu_fetch: RTL and testbench

Synthesizable instruction-fetch requester that drives the core's instruction-memory port. It replaces the simulation-only PC-to-instruction lookup with a real valid/ready request and response handshake. It owns the fetch PC, issues one 32-bit read at a time, and presents fetched instructions to ID through a single-entry output register. It honours ID stalls and redirects (branch, jump, trap), and drops stale responses.

---
 rtl/ysyx_25060170_ifu_fetch.sv | 191 +++++++++++++++++++
 tb/tb_ysyx_25060170_ifu_fetch.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_ifu_fetch.sv
// ysyx_25060170_ifu_fetch: instruction-fetch requester with one outstanding read.
// Ports: clk/rst (async, active-low), req_* to imem, rsp_* from imem,
// redirect_* flush, id_stall backpressure, if_* single-entry output to ID.
module ysyx_25060170_ifu_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_data,
    input  logic              rsp_err,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_stall,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst,
    output logic              if_fault
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]       skid_inst_q, skid_inst_d;
    logic              skid_fault_q, skid_fault_d;
    logic              ov_d;
    logic [ADDR_W-1:0] opc_d;
    logic [31:0]       oinst_d;
    logic              ofault_d;

    logic              req_fire;
    logic              consume;
    logic [ADDR_W-1:0] redir_pc;

    // run_q keeps req_valid low in the first cycle after reset release
    assign req_valid = run_q & (state_q == S_REQ);
    assign req_addr  = pc_q;
    assign req_fire  = req_valid & req_ready;
    assign consume   = if_valid & ~id_stall;
    assign redir_pc  = redirect_pc & ~ADDR_W'(3);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        skid_fault_d = skid_fault_q;
        ov_d         = if_valid;
        opc_d        = if_pc;
        oinst_d      = if_inst;
        ofault_d     = if_fault;

        if (redirect_valid) begin
            ov_d         = 1'b0;
            skid_pc_d    = '0;
            skid_inst_d  = '0;
            skid_fault_d = 1'b0;
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        // old address goes out anyway; its data is dropped
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                        pend_d  = 1'b0;
                        pc_d    = redir_pc;
                    end else if (req_valid) begin
                        // req_addr must stay stable until accepted
                        pend_d    = 1'b1;
                        pend_pc_d = redir_pc;
                    end else begin
                        pc_d = redir_pc;
                    end
                end
                S_WAIT: begin
                    pc_d = redir_pc;
                    if (rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            if (consume) begin
                ov_d = 1'b0;
            end
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d = S_WAIT;
                        if (pend_q) begin
                            drop_d = 1'b1;
                            pend_d = 1'b0;
                            pc_d   = pend_pc_q;
                        end
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        state_d = S_REQ;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            pc_d = pc_q + ADDR_W'(4);
                            if (consume || !if_valid) begin
                                ov_d     = 1'b1;
                                opc_d    = pc_q;
                                oinst_d  = rsp_data;
                                ofault_d = rsp_err;
                            end else begin
                                skid_pc_d    = pc_q;
                                skid_inst_d  = rsp_data;
                                skid_fault_d = rsp_err;
                                state_d      = S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        ov_d         = 1'b1;
                        opc_d        = skid_pc_q;
                        oinst_d      = skid_inst_q;
                        ofault_d     = skid_fault_q;
                        skid_pc_d    = '0;
                        skid_inst_d  = '0;
                        skid_fault_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_REQ;
            run_q        <= 1'b0;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
            skid_pc_q    <= '0;
            skid_inst_q  <= '0;
            skid_fault_q <= 1'b0;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_inst      <= '0;
            if_fault     <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= 1'b1;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
            skid_fault_q <= skid_fault_d;
            if_valid     <= ov_d;
            if_pc        <= opc_d;
            if_inst      <= oinst_d;
            if_fault     <= ofault_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// tb_ysyx_25060170_ifu_fetch: directed scenarios plus a randomized run
// checked against an instruction-stream model (pc sequence + memory image).
module tb_ysyx_25060170_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_25060170_ifu_fetch #(
        .ADDR_W  (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_stall      (id_stall),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_fault      (if_fault)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic merr(input logic [31:0] a);
        return a[4] & a[2];
    endfunction

    task automatic idle_inputs();
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        rsp_err        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_stall       = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data = 32'h1234_5678;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1000;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b0, RST_PC}) begin
            n_bad++;
            $display("FAIL rst_req: got %b/%h exp 0/%h", req_valid, req_addr, RST_PC);
        end
        n_cmp++;
        if ({if_valid, if_pc, if_inst, if_fault} !== 66'd0) begin
            n_bad++;
            $display("FAIL rst_if: got %b/%h/%h/%b exp all zero",
                     if_valid, if_pc, if_inst, if_fault);
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, RST_PC}) begin
            n_bad++;
            $display("FAIL rst_first_req: got %b/%h exp 1/%h", req_valid, req_addr, RST_PC);
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data = 32'h1111_2222;
        @(negedge clk);
        rsp_valid = 1'b0;
        n_cmp++;
        if ({if_valid, if_inst} !== {1'b1, 32'h1111_2222}) begin
            n_bad++;
            $display("FAIL rst_pre_if: got %b/%h exp 1/11112222", if_valid, if_inst);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({if_valid, if_inst, req_valid, req_addr} !== {1'b1 ^ 1'b1, 32'd0, 1'b0, RST_PC}) begin
            n_bad++;
            $display("FAIL rst_async: got %b/%h/%b/%h exp 0/0/0/%h",
                     if_valid, if_inst, req_valid, req_addr, RST_PC);
        end
        @(negedge clk);
        rst = 1'b1;
        rsp_valid = 1'b1;
        rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rsp_valid = 1'b0;
        n_cmp++;
        if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, RST_PC}) begin
            n_bad++;
            $display("FAIL rst_stray_rsp: got %b/%b/%h exp 0/1/%h",
                     if_valid, req_valid, req_addr, RST_PC);
        end
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        n_cmp++;
        if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, RST_PC}) begin
            n_bad++;
            $display("FAIL req_stray_rsp: got %b/%b/%h exp 0/1/%h",
                     if_valid, req_valid, req_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        apply_reset();
        req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rsp_valid = 1'b0;
            a = RST_PC + 32'(4 * i);
            if (i > 0) begin
                n_cmp++;
                if ({if_valid, if_pc, if_inst, if_fault} !==
                    {1'b1, a - 32'd4, mdata(a - 32'd4), merr(a - 32'd4)}) begin
                    n_bad++;
                    $display("FAIL seq_if%0d: got %b/%h/%h exp 1/%h/%h",
                             i, if_valid, if_pc, if_inst, a - 32'd4, mdata(a - 32'd4));
                end
            end
            n_cmp++;
            if ({req_valid, req_addr} !== {1'b1, a}) begin
                n_bad++;
                $display("FAIL seq_req%0d: got %b/%h exp 1/%h", i, req_valid, req_addr, a);
            end
            @(negedge clk);
            n_cmp++;
            if ({req_valid, if_valid} !== 2'b00) begin
                n_bad++;
                $display("FAIL seq_wait%0d: got req %b if %b exp 0/0", i, req_valid, if_valid);
            end
            rsp_valid = 1'b1;
            rsp_data = mdata(a);
            rsp_err = merr(a);
        end
        @(negedge clk);
        rsp_valid = 1'b0;
        n_cmp++;
        if ({if_valid, if_pc, if_inst, req_addr} !==
            {1'b1, 32'h8000_0008, mdata(32'h8000_0008), 32'h8000_000C}) begin
            n_bad++;
            $display("FAIL seq_last: got %b/%h/%h req %h exp 1/80000008/%h req 8000000c",
                     if_valid, if_pc, if_inst, req_addr, mdata(32'h8000_0008));
        end
    endtask

    task automatic test_stall_skid();
        logic [31:0] a0, a1;
        a0 = RST_PC;
        a1 = RST_PC + 32'd4;
        apply_reset();
        req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data = mdata(a0);
        @(negedge clk);
        rsp_valid = 1'b0;
        id_stall = 1'b1;
        n_cmp++;
        if ({if_valid, if_pc, req_valid, req_addr} !== {1'b1, a0, 1'b1, a1}) begin
            n_bad++;
            $display("FAIL skid_pre: got %b/%h req %b/%h exp 1/%h req 1/%h",
                     if_valid, if_pc, req_valid, req_addr, a0, a1);
        end
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data = mdata(a1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rsp_valid = 1'b0;
            n_cmp++;
            if ({if_valid, if_pc, if_inst, req_valid} !== {1'b1, a0, mdata(a0), 1'b0}) begin
                n_bad++;
                $display("FAIL skid_hold%0d: got %b/%h/%h req %b exp 1/%h/%h req 0",
                         k, if_valid, if_pc, if_inst, req_valid, a0, mdata(a0));
            end
        end
        id_stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({if_valid, if_pc, if_inst, req_valid, req_addr} !==
            {1'b1, a1, mdata(a1), 1'b1, a1 + 32'd4}) begin
            n_bad++;
            $display("FAIL skid_out: got %b/%h/%h req %b/%h exp 1/%h/%h req 1/%h",
                     if_valid, if_pc, if_inst, req_valid, req_addr, a1, mdata(a1), a1 + 32'd4);
        end
        @(negedge clk);
        n_cmp++;
        if ({if_valid, req_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL skid_nodup: got if %b req %b exp 0/0", if_valid, req_valid);
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] r;
        r = 32'h8000_1000;
        apply_reset();
        req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_1002;
        @(negedge clk);
        redirect_valid = 1'b0;
        rsp_valid = 1'b1;
        rsp_data = mdata(RST_PC);
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rw_wait: got req %b exp 0", req_valid);
        end
        @(negedge clk);
        rsp_valid = 1'b0;
        req_ready = 1'b1;
        n_cmp++;
        if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, r}) begin
            n_bad++;
            $display("FAIL rw_restart: got %b req %b/%h exp 0 req 1/%h",
                     if_valid, req_valid, req_addr, r);
        end
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data = mdata(r);
        @(negedge clk);
        rsp_valid = 1'b0;
        n_cmp++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, r, mdata(r)}) begin
            n_bad++;
            $display("FAIL rw_if: got %b/%h/%h exp 1/%h/%h", if_valid, if_pc, if_inst, r, mdata(r));
        end
    endtask

    task automatic test_redirect_pending();
        logic [31:0] r;
        r = 32'h8000_2000;
        apply_reset();
        req_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = r;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, RST_PC}) begin
            n_bad++;
            $display("FAIL rp_hold: got %b/%h exp 1/%h", req_valid, req_addr, RST_PC);
        end
        @(negedge clk);
        req_ready = 1'b1;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, RST_PC}) begin
            n_bad++;
            $display("FAIL rp_accept: got %b/%h exp 1/%h", req_valid, req_addr, RST_PC);
        end
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data = mdata(RST_PC);
        @(negedge clk);
        rsp_valid = 1'b0;
        req_ready = 1'b1;
        n_cmp++;
        if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, r}) begin
            n_bad++;
            $display("FAIL rp_restart: got %b req %b/%h exp 0 req 1/%h",
                     if_valid, req_valid, req_addr, r);
        end
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data = mdata(r);
        @(negedge clk);
        rsp_valid = 1'b0;
        n_cmp++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, r, mdata(r)}) begin
            n_bad++;
            $display("FAIL rp_if: got %b/%h/%h exp 1/%h/%h", if_valid, if_pc, if_inst, r, mdata(r));
        end
    endtask

    task automatic test_redirect_rsp_same();
        logic [31:0] r;
        r = 32'h8000_3000;
        apply_reset();
        req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data = mdata(RST_PC);
        @(negedge clk);
        rsp_valid = 1'b0;
        id_stall = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data = mdata(RST_PC + 32'd4);
        redirect_valid = 1'b1;
        redirect_pc = r;
        @(negedge clk);
        rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        n_cmp++;
        if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, r}) begin
            n_bad++;
            $display("FAIL rs_flush: got %b req %b/%h exp 0 req 1/%h",
                     if_valid, req_valid, req_addr, r);
        end
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data = mdata(r);
        @(negedge clk);
        rsp_valid = 1'b0;
        n_cmp++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, r, mdata(r)}) begin
            n_bad++;
            $display("FAIL rs_if: got %b/%h/%h exp 1/%h/%h", if_valid, if_pc, if_inst, r, mdata(r));
        end
    endtask

    task automatic test_wrap_fault();
        logic [31:0] r;
        r = 32'hFFFF_FFFC;
        apply_reset();
        req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = r;
        @(negedge clk);
        redirect_valid = 1'b0;
        rsp_valid = 1'b1;
        rsp_data = mdata(RST_PC);
        @(negedge clk);
        rsp_valid = 1'b0;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, r}) begin
            n_bad++;
            $display("FAIL wrap_req: got %b/%h exp 1/%h", req_valid, req_addr, r);
        end
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data = mdata(r);
        rsp_err = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_err = 1'b0;
        n_cmp++;
        if ({if_valid, if_pc, if_fault, req_valid, req_addr} !== {1'b1, r, 1'b1, 1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL wrap_if: got %b/%h/f%b req %b/%h exp 1/%h/f1 req 1/00000000",
                     if_valid, if_pc, if_fault, req_valid, req_addr, r);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, out_addr, prev_addr, h_pc, h_inst;
        logic        out_q, prev_wait, h_v, h_f;
        int          wait_n, n_cons;
        apply_reset();
        exp_pc = RST_PC;
        out_addr = '0;
        prev_addr = '0;
        h_pc = '0;
        h_inst = '0;
        h_f = 1'b0;
        out_q = 1'b0;
        prev_wait = 1'b0;
        h_v = 1'b0;
        wait_n = 0;
        n_cons = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (prev_wait) begin
                n_cmp++;
                if ({req_valid, req_addr} !== {1'b1, prev_addr}) begin
                    n_bad++;
                    $display("FAIL rnd_req_stable: got %b/%h exp 1/%h", req_valid, req_addr, prev_addr);
                end
            end
            if (h_v) begin
                n_cmp++;
                if ({if_valid, if_pc, if_inst, if_fault} !== {1'b1, h_pc, h_inst, h_f}) begin
                    n_bad++;
                    $display("FAIL rnd_stall_hold: got %b/%h/%h exp 1/%h/%h",
                             if_valid, if_pc, if_inst, h_pc, h_inst);
                end
            end
            if (req_valid) begin
                n_cmp++;
                if (out_q || req_addr[1:0] !== 2'b00) begin
                    n_bad++;
                    $display("FAIL rnd_req_legal: outstanding %b addr %h exp 0/aligned", out_q, req_addr);
                end
            end
            rsp_valid = out_q && (wait_n == 0);
            rsp_data = rsp_valid ? mdata(out_addr) : $urandom;
            rsp_err = rsp_valid ? merr(out_addr) : 1'($urandom_range(0, 1));
            req_ready = ($urandom_range(0, 3) != 0);
            id_stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0)
                redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else
                redirect_pc = RST_PC | ($urandom_range(0, 4095) << 2) | $urandom_range(0, 3);
            if (if_valid && !id_stall && !redirect_valid) begin
                n_cmp++;
                if ({if_pc, if_inst, if_fault} !== {exp_pc, mdata(exp_pc), merr(exp_pc)}) begin
                    n_bad++;
                    $display("FAIL rnd_stream: got %h/%h/%b exp %h/%h/%b",
                             if_pc, if_inst, if_fault, exp_pc, mdata(exp_pc), merr(exp_pc));
                    exp_pc = if_pc;
                end
                exp_pc += 32'd4;
                n_cons++;
            end
            if (redirect_valid)
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            prev_wait = req_valid && !req_ready;
            prev_addr = req_addr;
            h_v = if_valid && id_stall && !redirect_valid;
            h_pc = if_pc;
            h_inst = if_inst;
            h_f = if_fault;
            if (rsp_valid)
                out_q = 1'b0;
            else if (out_q)
                wait_n--;
            if (req_valid && req_ready) begin
                out_q = 1'b1;
                out_addr = req_addr;
                wait_n = $urandom_range(0, 2);
            end
        end
        idle_inputs();
        n_cmp++;
        if (n_cons < 100) begin
            n_bad++;
            $display("FAIL rnd_progress: got %0d instructions exp >= 100", n_cons);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_pending();
        test_redirect_rsp_same();
        test_wrap_fault();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
